// File: rtl/exec_bypass_unit.sv
// Execute-stage operand bypass with load-use stall detection and a small
// history buffer holding WB writes that retire while execute is held.
module exec_bypass_unit #(
  parameter int XLEN       = 32,
  parameter int RBITS      = 5,
  parameter int NSRC       = 2,
  parameter int NWR        = 2,
  parameter int HIST_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  halt,
  input  logic                  ex_valid,
  input  logic [NSRC*RBITS-1:0] src,
  input  logic [NSRC*XLEN-1:0]  rf_data,
  input  logic                  exo_valid,
  input  logic                  exo_load,
  input  logic [NWR*RBITS-1:0]  exo_tgt,
  input  logic [NWR*XLEN-1:0]   exo_res,
  input  logic                  mem_valid,
  input  logic                  mem_load,
  input  logic [NWR*RBITS-1:0]  mem_tgt,
  input  logic [NWR*XLEN-1:0]   mem_res,
  input  logic                  wb_valid,
  input  logic [NWR*RBITS-1:0]  wb_tgt,
  input  logic [NWR*XLEN-1:0]   wb_res,
  output logic [NSRC*XLEN-1:0]  op,
  output logic                  stall,
  output logic [NSRC-1:0]       fwd_hit,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [HIST_DEPTH-1:0] hist_valid
);

  localparam int NCAND = (3 + HIST_DEPTH) * NWR;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {RUN, STALL} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [HIST_DEPTH-1:0]   hist_valid_q, hist_valid_d;
  logic [RBITS-1:0]        hist_tgt_q [HIST_DEPTH][NWR];
  logic [RBITS-1:0]        hist_tgt_d [HIST_DEPTH][NWR];
  logic [XLEN-1:0]         hist_res_q [HIST_DEPTH][NWR];
  logic [XLEN-1:0]         hist_res_d [HIST_DEPTH][NWR];

  // Flattened candidate list in priority order: exo, mem, wb, history newest..oldest.
  logic [NCAND-1:0]        cand_v;
  logic [NCAND-1:0]        cand_l;
  logic [RBITS-1:0]        cand_t [NCAND];
  logic [XLEN-1:0]         cand_r [NCAND];
  logic [NSRC-1:0]         src_ld;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NWR; gi++) begin : g_pipe_cand
      assign cand_v[gi]         = exo_valid;
      assign cand_l[gi]         = exo_load;
      assign cand_t[gi]         = exo_tgt[gi*RBITS +: RBITS];
      assign cand_r[gi]         = exo_res[gi*XLEN +: XLEN];
      assign cand_v[NWR+gi]     = mem_valid;
      assign cand_l[NWR+gi]     = mem_load;
      assign cand_t[NWR+gi]     = mem_tgt[gi*RBITS +: RBITS];
      assign cand_r[NWR+gi]     = mem_res[gi*XLEN +: XLEN];
      assign cand_v[2*NWR+gi]   = wb_valid;
      assign cand_l[2*NWR+gi]   = 1'b0;
      assign cand_t[2*NWR+gi]   = wb_tgt[gi*RBITS +: RBITS];
      assign cand_r[2*NWR+gi]   = wb_res[gi*XLEN +: XLEN];
    end

    for (gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist_cand
      for (gj = 0; gj < NWR; gj++) begin : g_slot
        assign cand_v[(3+gi)*NWR+gj] = hist_valid_q[gi];
        assign cand_l[(3+gi)*NWR+gj] = 1'b0;
        assign cand_t[(3+gi)*NWR+gj] = hist_tgt_q[gi][gj];
        assign cand_r[(3+gi)*NWR+gj] = hist_res_q[gi][gj];
      end
    end

    for (gi = 0; gi < NSRC; gi++) begin : g_src
      logic [RBITS-1:0] sreg;
      logic [XLEN-1:0]  sel;
      logic             hit;
      logic             ld;

      assign sreg = src[gi*RBITS +: RBITS];

      // Scan from lowest priority upward so the highest-priority match lands last.
      always_comb begin
        sel = rf_data[gi*XLEN +: XLEN];
        hit = 1'b0;
        ld  = 1'b0;
        if (sreg != '0) begin
          for (int c = NCAND - 1; c >= 0; c--) begin
            if (cand_v[c] && (cand_t[c] == sreg)) begin
              sel = cand_r[c];
              hit = 1'b1;
            end
          end
          for (int c = 0; c < 2 * NWR; c++) begin
            if (cand_v[c] && cand_l[c] && (cand_t[c] == sreg)) ld = 1'b1;
          end
        end
      end

      assign op[gi*XLEN +: XLEN] = sel;
      assign fwd_hit[gi]         = hit;
      assign src_ld[gi]          = ld;
    end
  endgenerate

  assign stall        = ex_valid && (|src_ld);
  assign stall_cycles = cnt_q;
  assign hist_valid   = hist_valid_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hist_valid_d = hist_valid_q;
    hist_tgt_d   = hist_tgt_q;
    hist_res_d   = hist_res_q;
    if (!halt) begin
      if (stall) begin
        state_d = STALL;
        if (state_q == RUN) cnt_d = CNT_W'(1);
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        for (int h = HIST_DEPTH - 1; h > 0; h--) begin
          hist_valid_d[h] = hist_valid_q[h-1];
          hist_tgt_d[h]   = hist_tgt_q[h-1];
          hist_res_d[h]   = hist_res_q[h-1];
        end
        hist_valid_d[0] = wb_valid;
        for (int w = 0; w < NWR; w++) begin
          hist_tgt_d[0][w] = wb_tgt[w*RBITS +: RBITS];
          hist_res_d[0][w] = wb_res[w*XLEN +: XLEN];
        end
      end else begin
        // Operands were consumed this cycle, so retained writes are stale.
        state_d      = RUN;
        hist_valid_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      hist_valid_q <= '0;
      for (int h = 0; h < HIST_DEPTH; h++) begin
        for (int w = 0; w < NWR; w++) begin
          hist_tgt_q[h][w] <= '0;
          hist_res_q[h][w] <= '0;
        end
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hist_valid_q <= hist_valid_d;
      hist_tgt_q   <= hist_tgt_d;
      hist_res_q   <= hist_res_d;
    end
  end

endmodule

// File: tb/tb_exec_bypass_unit.sv
// Randomised bench for exec_bypass_unit: a queue-based behavioural model is
// compared every cycle, with a few hand-computed scenarios pinning the model.
module tb_exec_bypass_unit;
  localparam int XLEN = 32, RBITS = 5, NSRC = 2, NWR = 2, HIST_DEPTH = 2, CNT_W = 16;

  logic                  clk = 1'b0;
  logic                  rst_n, halt, ex_valid;
  logic [NSRC*RBITS-1:0] src;
  logic [NSRC*XLEN-1:0]  rf_data;
  logic                  exo_valid, exo_load, mem_valid, mem_load, wb_valid;
  logic [NWR*RBITS-1:0]  exo_tgt, mem_tgt, wb_tgt;
  logic [NWR*XLEN-1:0]   exo_res, mem_res, wb_res;
  logic [NSRC*XLEN-1:0]  op;
  logic                  stall;
  logic [NSRC-1:0]       fwd_hit;
  logic [CNT_W-1:0]      stall_cycles;
  logic [HIST_DEPTH-1:0] hist_valid;

  exec_bypass_unit #(.XLEN(XLEN), .RBITS(RBITS), .NSRC(NSRC), .NWR(NWR),
                     .HIST_DEPTH(HIST_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .ex_valid(ex_valid), .src(src), .rf_data(rf_data),
    .exo_valid(exo_valid), .exo_load(exo_load), .exo_tgt(exo_tgt), .exo_res(exo_res),
    .mem_valid(mem_valid), .mem_load(mem_load), .mem_tgt(mem_tgt), .mem_res(mem_res),
    .wb_valid(wb_valid), .wb_tgt(wb_tgt), .wb_res(wb_res),
    .op(op), .stall(stall), .fwd_hit(fwd_hit), .stall_cycles(stall_cycles), .hist_valid(hist_valid));

  always #5 clk = ~clk;

  typedef struct packed {
    logic                 v;
    logic [NWR*RBITS-1:0] t;
    logic [NWR*XLEN-1:0]  r;
  } hent_t;

  hent_t                 mh[$];          // newest at index 0
  logic                  m_stalling;
  logic [CNT_W-1:0]      m_cnt;
  logic [XLEN-1:0]       e_op [NSRC];
  logic [NSRC-1:0]       e_hit;
  logic                  e_stall;
  logic [HIST_DEPTH-1:0] e_hv;
  int                    vectors = 0;
  int                    miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mh.delete();
    m_stalling = 1'b0;
    m_cnt      = '0;
  endtask

  task automatic model_eval();
    logic                 v, found, ld;
    logic [NWR*RBITS-1:0] t;
    logic [NWR*XLEN-1:0]  r;
    logic [RBITS-1:0]     s;
    e_stall = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      s        = src[i*RBITS +: RBITS];
      e_op[i]  = rf_data[i*XLEN +: XLEN];
      e_hit[i] = 1'b0;
      found    = 1'b0;
      ld       = 1'b0;
      if (s != 0) begin
        for (int k = 0; k < 3 + mh.size(); k++) begin
          case (k)
            0:       begin v = exo_valid; t = exo_tgt; r = exo_res; end
            1:       begin v = mem_valid; t = mem_tgt; r = mem_res; end
            2:       begin v = wb_valid;  t = wb_tgt;  r = wb_res;  end
            default: begin v = mh[k-3].v; t = mh[k-3].t; r = mh[k-3].r; end
          endcase
          for (int w = 0; w < NWR; w++) begin
            if (!found && v && t[w*RBITS +: RBITS] == s) begin
              found    = 1'b1;
              e_op[i]  = r[w*XLEN +: XLEN];
              e_hit[i] = 1'b1;
            end
          end
        end
        for (int w = 0; w < NWR; w++) begin
          if (exo_valid && exo_load && exo_tgt[w*RBITS +: RBITS] == s) ld = 1'b1;
          if (mem_valid && mem_load && mem_tgt[w*RBITS +: RBITS] == s) ld = 1'b1;
        end
      end
      if (ex_valid && ld) e_stall = 1'b1;
    end
    for (int h = 0; h < HIST_DEPTH; h++) e_hv[h] = (h < mh.size()) ? mh[h].v : 1'b0;
  endtask

  task automatic model_clock();
    hent_t e;
    if (halt) return;
    if (e_stall) begin
      if (!m_stalling) m_cnt = 1;
      else if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1;
      m_stalling = 1'b1;
      e.v = wb_valid; e.t = wb_tgt; e.r = wb_res;
      mh.push_front(e);
      if (mh.size() > HIST_DEPTH) void'(mh.pop_back());
    end else begin
      m_stalling = 1'b0;
      mh.delete();
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NSRC; i++) begin
      check($sformatf("op%0d", i), 64'(op[i*XLEN +: XLEN]), 64'(e_op[i]));
      check($sformatf("fwd_hit%0d", i), 64'(fwd_hit[i]), 64'(e_hit[i]));
    end
    check("stall", 64'(stall), 64'(e_stall));
    check("hist_valid", 64'(hist_valid), 64'(e_hv));
    check("stall_cycles", 64'(stall_cycles), 64'(m_cnt));
  endtask

  // Called at negedge+1 with inputs settled; optionally pulses reset mid-cycle.
  task automatic cycle(input bit do_rst);
    model_eval();
    compare_all();
    if (do_rst) begin
      rst_n = 1'b0;
      #1;
      model_reset();
      model_eval();
      check("rst_hist_valid", 64'(hist_valid), 64'd0);
      check("rst_stall_cycles", 64'(stall_cycles), 64'd0);
      check("rst_stall", 64'(stall), 64'(e_stall));
      #1 rst_n = 1'b1;
    end
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle();
    halt = 0; ex_valid = 0; src = '0; rf_data = '0;
    exo_valid = 0; exo_load = 0; exo_tgt = '0; exo_res = '0;
    mem_valid = 0; mem_load = 0; mem_tgt = '0; mem_res = '0;
    wb_valid = 0; wb_tgt = '0; wb_res = '0;
  endtask

  task automatic load_stall_inputs(input logic [RBITS-1:0] wreg, input logic [XLEN-1:0] wval);
    idle();
    ex_valid = 1; src[0 +: RBITS] = 7;
    exo_valid = 1; exo_load = 1; exo_tgt[0 +: RBITS] = 7; exo_res[0 +: XLEN] = 32'hDEAD;
    wb_valid = 1; wb_tgt[0 +: RBITS] = wreg; wb_res[0 +: XLEN] = wval;
  endtask

  initial begin
    idle();
    rst_n = 0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("reset_hist_valid", 64'(hist_valid), 64'd0);
    check("reset_stall_cycles", 64'(stall_cycles), 64'd0);
    rst_n = 1;
    @(negedge clk);

    // Exo beats mem; register 0 never forwarded.
    idle();
    ex_valid = 1; src[0 +: RBITS] = 5; src[RBITS +: RBITS] = 0;
    exo_valid = 1; exo_tgt[0 +: RBITS] = 5; exo_res[0 +: XLEN] = 32'hAAAA;
    exo_tgt[RBITS +: RBITS] = 0; exo_res[XLEN +: XLEN] = 32'h1234;
    mem_valid = 1; mem_tgt[0 +: RBITS] = 5; mem_res[0 +: XLEN] = 32'hBBBB;
    #1;
    check("t1_op0", 64'(op[0 +: XLEN]), 64'hAAAA);
    check("t1_hit0", 64'(fwd_hit[0]), 64'd1);
    check("t1_stall", 64'(stall), 64'd0);
    check("t2_op1", 64'(op[XLEN +: XLEN]), 64'd0);
    check("t2_hit1", 64'(fwd_hit[1]), 64'd0);
    cycle(0);

    // Two-cycle load-use stall capturing r3 then r4.
    load_stall_inputs(3, 32'h33);
    #1;
    check("t3_stall_a", 64'(stall), 64'd1);
    cycle(0);
    load_stall_inputs(4, 32'h44);
    #1;
    check("t3_stall_b", 64'(stall), 64'd1);
    check("t3_cnt_b", 64'(stall_cycles), 64'd1);
    cycle(0);
    idle();
    ex_valid = 1; src[0 +: RBITS] = 3; src[RBITS +: RBITS] = 4;
    rf_data = {32'h2222_0000, 32'h1111_0000};
    #1;
    check("t3_cnt", 64'(stall_cycles), 64'd2);
    check("t3_hv", 64'(hist_valid), 64'b11);
    check("t3_op0", 64'(op[0 +: XLEN]), 64'h33);
    check("t3_op1", 64'(op[XLEN +: XLEN]), 64'h44);
    check("t3_stall_c", 64'(stall), 64'd0);
    cycle(0);
    idle();
    ex_valid = 1; src[0 +: RBITS] = 3; rf_data[0 +: XLEN] = 32'hCAFE;
    #1;
    check("t4_hv", 64'(hist_valid), 64'd0);
    check("t4_op0", 64'(op[0 +: XLEN]), 64'hCAFE);
    check("t4_hit0", 64'(fwd_hit[0]), 64'd0);
    check("t4_cnt_hold", 64'(stall_cycles), 64'd2);
    cycle(0);

    // Three-cycle stall with depth 2: r1 falls out, r2/r3 retained.
    load_stall_inputs(1, 32'h11); #1; cycle(0);
    load_stall_inputs(2, 32'h22); #1; cycle(0);
    load_stall_inputs(3, 32'h3333); #1; cycle(0);
    idle();
    ex_valid = 1; src[0 +: RBITS] = 1; src[RBITS +: RBITS] = 2;
    rf_data[0 +: XLEN] = 32'h0101;
    #1;
    check("t5_cnt", 64'(stall_cycles), 64'd3);
    check("t5_op0_dropped", 64'(op[0 +: XLEN]), 64'h0101);
    check("t5_op1", 64'(op[XLEN +: XLEN]), 64'h22);
    cycle(0);

    // Asynchronous reset in the middle of a stall.
    load_stall_inputs(8, 32'h88); #1; cycle(0);
    load_stall_inputs(9, 32'h99); #1;
    check("t6_hv_pre", 64'(hist_valid), 64'b01);
    cycle(0);
    load_stall_inputs(10, 32'hAA); #1;
    check("t6_hv_pre2", 64'(hist_valid), 64'b11);
    check("t6_cnt_pre", 64'(stall_cycles), 64'd2);
    cycle(1);

    // Randomised phase.
    for (int n = 0; n < 600; n++) begin
      halt      = ($urandom_range(0, 9) == 0);
      ex_valid  = ($urandom_range(0, 9) < 8);
      exo_valid = ($urandom_range(0, 9) < 7);
      exo_load  = ($urandom_range(0, 9) < 3);
      mem_valid = ($urandom_range(0, 9) < 7);
      mem_load  = ($urandom_range(0, 9) < 3);
      wb_valid  = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NSRC; i++) begin
        src[i*RBITS +: RBITS]  = RBITS'($urandom_range(0, 7));
        rf_data[i*XLEN +: XLEN] = $urandom;
      end
      for (int w = 0; w < NWR; w++) begin
        exo_tgt[w*RBITS +: RBITS] = RBITS'($urandom_range(0, 7));
        mem_tgt[w*RBITS +: RBITS] = RBITS'($urandom_range(0, 7));
        wb_tgt[w*RBITS +: RBITS]  = RBITS'($urandom_range(0, 7));
        exo_res[w*XLEN +: XLEN]   = $urandom;
        mem_res[w*XLEN +: XLEN]   = $urandom;
        wb_res[w*XLEN +: XLEN]    = $urandom;
      end
      #1;
      cycle($urandom_range(0, 39) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
